// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the multi-lane Mandelbrot coordinate engine.
// Fixed-point layout is 1 sign bit, 4 integer bits, remainder fraction.
package mandelbrot_pkg;

    localparam int FP_S   = 1;
    localparam int FP_I   = 4;
    localparam int FP_F   = 27 - FP_S - FP_I;
    localparam int MAX_NL = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [4:0] popcount(input logic [MAX_NL-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_NL; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/mandelbrot_lane_offsets.sv
// Builds per-lane x offsets (k*xs) and the beat stride (NL*xs) by repeated
// addition, one lane per enabled edge, so no multiplier is needed.
module mandelbrot_lane_offsets
    import mandelbrot_pkg::*;
#(
    parameter int FPW = 27,
    parameter int NL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic signed [FPW-1:0] i_xs,
    output logic                  o_busy,
    output logic                  o_last,
    output logic [NL*FPW-1:0]     o_off,
    output logic signed [FPW-1:0] o_stride
);

    localparam int IW = (NL > 1) ? $clog2(NL) : 1;

    logic                  r_busy;
    logic [IW-1:0]         r_idx;
    logic signed [FPW-1:0] r_xs;
    logic signed [FPW-1:0] r_acc;
    logic signed [FPW-1:0] r_off [NL];
    logic signed [FPW-1:0] r_stride;
    logic                  w_last;

    assign w_last = (r_idx == IW'(NL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_xs     <= '0;
            r_acc    <= '0;
            r_stride <= '0;
            for (int k = 0; k < NL; k++) begin
                r_off[k] <= '0;
            end
        end else if (clk_en) begin
            if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_acc  <= '0;
                r_xs   <= i_xs;
            end else if (i_clear) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                // r_acc holds idx*xs; the final lane also yields the stride
                r_off[r_idx] <= r_acc;
                r_acc        <= r_acc + r_xs;
                if (w_last) begin
                    r_stride <= r_acc + r_xs;
                    r_busy   <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_pack
        assign o_off[k*FPW +: FPW] = r_off[k];
    end

    assign o_busy   = r_busy;
    assign o_last   = w_last;
    assign o_stride = r_stride;

endmodule

// File: rtl/mandelbrot_coords_lanes.sv
// Multi-lane Mandelbrot coordinate engine: walks a frame in beats of NL
// horizontally adjacent pixels, with row/frame markers and lane masks.
module mandelbrot_coords_lanes
    import mandelbrot_pkg::*;
#(
    parameter int CW  = 12,
    parameter int AW  = 21,
    parameter int FPW = 27,
    parameter int NL  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              init,
    input  logic              abort,
    output logic              done,
    input  logic [CW-1:0]     hres,
    input  logic [CW-1:0]     vres,
    input  logic [AW-1:0]     adr_base,
    input  logic [FPW-1:0]    man_x0,
    input  logic [FPW-1:0]    man_y0,
    input  logic [FPW-1:0]    man_xs,
    input  logic [FPW-1:0]    man_ys,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [NL*FPW-1:0] out_x,
    output logic [FPW-1:0]    out_y,
    output logic [AW-1:0]     out_adr,
    output logic [NL-1:0]     out_msk,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int EW = CW + 5;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt_x;
    logic [CW-1:0]         r_cnt_y;
    logic [CW-1:0]         r_hres;
    logic [CW-1:0]         r_vres;
    logic [AW-1:0]         r_adr;
    logic signed [FPW-1:0] r_x0;
    logic signed [FPW-1:0] r_ys;
    logic signed [FPW-1:0] r_xb;
    logic signed [FPW-1:0] r_yb;

    logic                  w_run;
    logic                  w_xfer;
    logic [EW-1:0]         w_cx_ext;
    logic [EW-1:0]         w_hres_ext;
    logic [NL-1:0]         w_msk;
    logic                  w_eol;
    logic                  w_eof;
    logic                  w_off_busy;
    logic                  w_off_last;
    logic [NL*FPW-1:0]     w_off;
    logic signed [FPW-1:0] w_stride;

    mandelbrot_lane_offsets #(
        .FPW (FPW),
        .NL  (NL)
    ) u_offsets (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .i_start  (init),
        .i_clear  (abort),
        .i_xs     (man_xs),
        .o_busy   (w_off_busy),
        .o_last   (w_off_last),
        .o_off    (w_off),
        .o_stride (w_stride)
    );

    assign w_run      = (r_state == ST_RUN);
    assign w_xfer     = w_run && out_rdy;
    assign w_cx_ext   = EW'(r_cnt_x);
    assign w_hres_ext = EW'(r_hres);

    always_comb begin
        w_msk = '0;
        for (int k = 0; k < NL; k++) begin
            w_msk[k] = w_run && ((w_cx_ext + EW'(k)) <= w_hres_ext);
        end
    end

    assign w_eol = w_run && ((w_cx_ext + EW'(NL)) > w_hres_ext);
    assign w_eof = w_eol && (r_cnt_y == r_vres);

    // init outranks abort, which outranks any same-cycle transfer
    always_comb begin
        w_state_nxt = r_state;
        if (init) begin
            w_state_nxt = ST_PREP;
        end else if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_PREP: if (w_off_busy && w_off_last) w_state_nxt = ST_RUN;
                ST_RUN:  if (w_xfer && w_eof)          w_state_nxt = ST_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
            r_hres  <= '0;
            r_vres  <= '0;
            r_adr   <= '0;
            r_x0    <= '0;
            r_ys    <= '0;
            r_xb    <= '0;
            r_yb    <= '0;
        end else if (clk_en) begin
            if (init) begin
                r_cnt_x <= '0;
                r_cnt_y <= '0;
                r_hres  <= hres;
                r_vres  <= vres;
                r_adr   <= adr_base;
                r_x0    <= man_x0;
                r_ys    <= man_ys;
                r_xb    <= man_x0;
                r_yb    <= man_y0;
            end else if (!abort && w_xfer) begin
                r_adr <= r_adr + AW'(popcount(MAX_NL'(w_msk)));
                if (!w_eol) begin
                    r_cnt_x <= r_cnt_x + CW'(NL);
                    r_xb    <= r_xb + w_stride;
                end else if (!w_eof) begin
                    r_cnt_x <= '0;
                    r_xb    <= r_x0;
                    r_cnt_y <= r_cnt_y + 1'b1;
                    r_yb    <= r_yb + r_ys;
                end
            end
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        assign out_x[k*FPW +: FPW] = r_xb + w_off[k*FPW +: FPW];
    end

    assign out_y   = r_yb;
    assign out_adr = r_adr;
    assign out_msk = w_msk;
    assign out_eol = w_eol;
    assign out_eof = w_eof;
    assign out_vld = w_run;
    assign done    = (r_state == ST_IDLE);

endmodule
